// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative radix-4 Booth multiplier.
package mul_pkg;

   // Control states of the multiplier FSM.
   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_e;

   // Radix-4 Booth digit windows {y[i+1], y[i], y[i-1]}.
   localparam logic [2:0] BOOTH_ZERO_LO = 3'b000;
   localparam logic [2:0] BOOTH_POS1_A  = 3'b001;
   localparam logic [2:0] BOOTH_POS1_B  = 3'b010;
   localparam logic [2:0] BOOTH_POS2    = 3'b011;
   localparam logic [2:0] BOOTH_NEG2    = 3'b100;
   localparam logic [2:0] BOOTH_NEG1_A  = 3'b101;
   localparam logic [2:0] BOOTH_NEG1_B  = 3'b110;
   localparam logic [2:0] BOOTH_ZERO_HI = 3'b111;

   // Number of Booth digits needed for a width-bit operand pair with 2-bit extension.
   function automatic int unsigned iter_of(input int unsigned width);
      return width / 2 + 1;
   endfunction

endpackage

// File: rtl/booth_iter_multiplier_if.sv
// Operand/product handshake bundle for booth_iter_multiplier.
interface booth_iter_multiplier_if #(
   parameter int unsigned WIDTH = 32
) ();

   logic                   flush;
   logic                   in_valid;
   logic                   in_ready;
   logic                   mul_signed;
   logic [WIDTH-1:0]       x;
   logic [WIDTH-1:0]       y;
   logic                   out_valid;
   logic                   out_ready;
   logic [2*WIDTH-1:0]     result;

   // Requester side: supplies operands, consumes the product.
   modport master (
      output flush, in_valid, mul_signed, x, y, out_ready,
      input  in_ready, out_valid, result
   );

   // Multiplier side.
   modport slave (
      input  flush, in_valid, mul_signed, x, y, out_ready,
      output in_ready, out_valid, result
   );

endinterface

// File: rtl/booth_pp_select.sv
// Radix-4 Booth partial-product selector: maps a 3-bit digit window onto
// 0, +X, +2X, -2X or -X at full accumulator width.
module booth_pp_select
   import mul_pkg::*;
#(
   parameter int unsigned AW = 68
) (
   input  logic [2:0]    digit,
   input  logic [AW-1:0] mcand,
   output logic [AW-1:0] pp
);

   // Decode the digit window into the signed multiple of the multiplicand.
   always_comb begin
      pp = '0;
      unique case (digit)
         BOOTH_ZERO_LO, BOOTH_ZERO_HI: pp = '0;
         BOOTH_POS1_A, BOOTH_POS1_B:   pp = mcand;
         BOOTH_POS2:                   pp = mcand << 1;
         BOOTH_NEG2:                   pp = ~(mcand << 1) + AW'(1);
         BOOTH_NEG1_A, BOOTH_NEG1_B:   pp = ~mcand + AW'(1);
         default:                      pp = '0;
      endcase
   end

endmodule

// File: rtl/booth_iter_multiplier.sv
// Iterative radix-4 Booth multiplier, one digit per cycle, valid/ready on both sides.
// Optional build macro: MUL_EARLY_TERM_EN -- finish as soon as the remaining
// multiplier bits can only produce zero digits.
module booth_iter_multiplier
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   booth_iter_multiplier_if.slave bus
);

   localparam int unsigned ITER = iter_of(WIDTH);
   localparam int unsigned AW   = 2 * WIDTH + 4;
   localparam int unsigned YW   = WIDTH + 3;
   localparam int unsigned CW   = $clog2(ITER);

   state_e          state_q, state_d;
   logic [AW-1:0]   x_q, x_d;
   logic [YW-1:0]   y_q, y_d;
   logic [AW-1:0]   acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [WIDTH+1:0] x_ext;
   logic [WIDTH+1:0] y_ext;
   logic [AW-1:0]    pp;
   logic [YW-1:0]    y_shift;
   logic             accept;
   logic             last_digit;
   logic             rest_zero;

   // 2-bit extension lets the top digit absorb the sign (or zero) of each operand.
   assign x_ext = {{2{bus.mul_signed & bus.x[WIDTH-1]}}, bus.x};
   assign y_ext = {{2{bus.mul_signed & bus.y[WIDTH-1]}}, bus.y};

   assign accept     = (state_q == IDLE) && bus.in_valid && !bus.flush;
   assign last_digit = (cnt_q == CW'(ITER - 1));
   assign y_shift    = YW'($signed(y_q) >>> 2);

`ifdef MUL_EARLY_TERM_EN
   // Once every remaining multiplier bit is equal, all later digits are zero.
   assign rest_zero = (y_shift == '0) || (y_shift == '1);
`else
   assign rest_zero = 1'b0;
`endif

   booth_pp_select #(
      .AW (AW)
   ) u_pp_select (
      .digit (y_q[2:0]),
      .mcand (x_q),
      .pp    (pp)
   );

   // Next-state logic; flush overrides every transition.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.in_valid) state_d = BUSY;
         BUSY:    if (last_digit || rest_zero) state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (bus.flush) begin
         state_d = IDLE;
      end
   end

   // Datapath next values: load on accept, retire one digit per BUSY cycle.
   always_comb begin
      x_d   = x_q;
      y_d   = y_q;
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (accept) begin
         // Multiplicand must be sign-extended through the whole field so that
         // two's-complement negation stays exact in the low product bits.
         x_d   = {{(AW - WIDTH - 2){x_ext[WIDTH+1]}}, x_ext};
         y_d   = {y_ext, 1'b0};
         acc_d = '0;
         cnt_d = '0;
      end else if (state_q == BUSY) begin
         acc_d = acc_q + pp;
         x_d   = x_q << 2;
         y_d   = y_shift;
         cnt_d = cnt_q + CW'(1);
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   // Accumulator is frozen outside BUSY, so it doubles as the held result register.
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.result    = acc_q[2*WIDTH-1:0];

   // Extension bits above the product are arithmetic scratch only.
   logic unused_acc;
   assign unused_acc = ^acc_q[AW-1:2*WIDTH];

endmodule

// File: tb/tb_booth_iter_multiplier.sv
// Directed self-checking bench for booth_iter_multiplier (WIDTH=32).
module tb_booth_iter_multiplier;

   localparam int unsigned WIDTH = 32;
   localparam int          ITER  = WIDTH / 2 + 1;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   booth_iter_multiplier_if #(.WIDTH(WIDTH)) bus ();

   booth_iter_multiplier #(
      .WIDTH (WIDTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
      longint sa;
      longint sb;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      return {32'b0, a} * {32'b0, b};
   endfunction

   // Present one operand pair, then scramble the inputs and count edges to out_valid.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [63:0] res, output int lat);
      @(negedge clk);
      check("ready_before_accept", 64'(bus.in_ready), 64'(1));
      bus.x          = a;
      bus.y          = b;
      bus.mul_signed = s;
      bus.in_valid   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid   = 1'b0;
      bus.x          = ~a;
      bus.y          = b ^ 32'h5a5a_5a5a;
      bus.mul_signed = ~s;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!bus.out_valid && lat < 40);
      res = bus.result;
   endtask

   task automatic check_lat(input string tag, input int lat, input int exp_full);
`ifdef MUL_EARLY_TERM_EN
      check(tag, 64'(lat >= 1 && lat <= exp_full), 64'(1));
`else
      check(tag, 64'(lat), 64'(exp_full));
`endif
   endtask

   task automatic take_result(input string tag);
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
      check({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
   endtask

   initial begin
      logic [63:0] res;
      int          lat;
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic        seen;

      checks         = 0;
      failures       = 0;
      reset          = 1'b1;
      bus.flush      = 1'b0;
      bus.in_valid   = 1'b0;
      bus.mul_signed = 1'b0;
      bus.x          = '0;
      bus.y          = '0;
      bus.out_ready  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Reset state.
      check("reset_in_ready", 64'(bus.in_ready), 64'(1));
      check("reset_out_valid", 64'(bus.out_valid), 64'(0));
      check("reset_result", bus.result, 64'h0);

      // Signed -1 x -1.
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, res, lat);
      check("s_m1_m1", res, 64'h0000_0000_0000_0001);
      check_lat("s_m1_m1_lat", lat, ITER);
      take_result("s_m1_m1_take");

      // Unsigned all-ones.
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, res, lat);
      check("u_ones", res, 64'hFFFF_FFFE_0000_0001);
      check_lat("u_ones_lat", lat, ITER);
      take_result("u_ones_take");

      // Signed most-negative squared.
      run_op(32'h8000_0000, 32'h8000_0000, 1'b1, res, lat);
      check("s_minmin", res, 64'h4000_0000_0000_0000);
      take_result("s_minmin_take");

      // Backpressure: 7 x 6 held for 10 cycles.
      run_op(32'd7, 32'd6, 1'b0, res, lat);
      check("bp_result", res, 64'd42);
      check_lat("bp_lat", lat, ITER);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("bp_hold_valid", 64'(bus.out_valid), 64'(1));
         check("bp_hold_result", bus.result, 64'd42);
         check("bp_hold_in_ready", 64'(bus.in_ready), 64'(0));
      end
      take_result("bp_take");

      // Flush on the fifth BUSY cycle with a competing in_valid.
      @(negedge clk);
      bus.x = 32'd9; bus.y = 32'd9; bus.mul_signed = 1'b0; bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      bus.flush = 1'b1; bus.in_valid = 1'b1; bus.x = 32'd11; bus.y = 32'd13;
      @(posedge clk);
      @(negedge clk);
      bus.flush = 1'b0; bus.in_valid = 1'b0;
      check("flush_in_ready", 64'(bus.in_ready), 64'(1));
      check("flush_out_valid", 64'(bus.out_valid), 64'(0));
      seen = 1'b0;
      repeat (25) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.out_valid || !bus.in_ready) seen = 1'b1;
      end
      check("flush_stays_idle", 64'(seen), 64'(0));
      run_op(32'd3, 32'hFFFF_FFFC, 1'b1, res, lat);
      check("post_flush_3xm4", res, 64'hFFFF_FFFF_FFFF_FFF4);
      take_result("post_flush_take");

      // Reset in the middle of BUSY clears everything.
      @(negedge clk);
      bus.x = 32'h1234_5678; bus.y = 32'h0ABC_DEF1; bus.mul_signed = 1'b0; bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst_busy_in_ready", 64'(bus.in_ready), 64'(1));
      check("rst_busy_out_valid", 64'(bus.out_valid), 64'(0));
      check("rst_busy_result", bus.result, 64'h0);

      // Small unsigned product: early termination shortens latency to two digits.
      run_op(32'd5, 32'd3, 1'b0, res, lat);
      check("u_5x3", res, 64'd15);
`ifdef MUL_EARLY_TERM_EN
      check("u_5x3_lat", 64'(lat), 64'(2));
`else
      check("u_5x3_lat", 64'(lat), 64'(ITER));
`endif
      take_result("u_5x3_take");

      // Random operands against the reference product.
      for (int i = 0; i < 200; i++) begin
         a = $urandom;
         b = $urandom;
         s = 1'($urandom_range(0, 1));
         if (i % 8 == 1) b = 32'($urandom_range(0, 15));
         if (i % 8 == 3) a = 32'h8000_0000;
         if (i % 8 == 5) b = 32'hFFFF_FFFF;
         run_op(a, b, s, res, lat);
         check("rand_result", res, ref_mul(a, b, s));
         check_lat("rand_lat", lat, ITER);
         take_result("rand_take");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
